// File: rtl/jesd204b_pkg.sv
// Shared constants and types for the JESD204B transmit link-layer sequencer.
package jesd204b_pkg;

    localparam logic [7:0] K28_0 = 8'h1C;  // /R/
    localparam logic [7:0] K28_3 = 8'h7C;  // /A/
    localparam logic [7:0] K28_4 = 8'h9C;  // /Q/
    localparam logic [7:0] K28_5 = 8'hBC;  // /K/
    localparam logic [7:0] K28_7 = 8'hFC;  // /F/

    localparam int ILAS_CFG_OCTETS = 14;
    localparam int SYNC_RESYNC_CNT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CGS  = 2'd1,
        ST_ILAS = 2'd2,
        ST_DATA = 2'd3
    } link_state_t;

endpackage

// File: rtl/jesd204b_lmfc_cnt.sv
// Multiframe octet counter with frame-position tracking and LMFC pulse.
module jesd204b_lmfc_cnt #(
    parameter int F     = 2,
    parameter int K     = 32,
    parameter int CNT_W = $clog2(F * K)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             lmfc,
    output logic             mf_end,
    output logic             frm_end
);

    localparam int FRM_W = (F > 1) ? $clog2(F) : 1;

    logic [FRM_W-1:0] frm_cnt;

    // Frame counter wraps together with the multiframe so frames stay LMFC-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            frm_cnt <= '0;
        end else if (clr || mf_end) begin
            cnt     <= '0;
            frm_cnt <= '0;
        end else begin
            cnt     <= cnt + CNT_W'(1);
            frm_cnt <= frm_end ? '0 : frm_cnt + FRM_W'(1);
        end
    end

    assign mf_end  = (cnt == CNT_W'(F * K - 1));
    assign frm_end = (frm_cnt == FRM_W'(F - 1));
    assign lmfc    = ~clr & (cnt == '0);

endmodule

// File: rtl/jesd204b_tx_link_ctrl.sv
// Single-lane JESD204B TX link sequencer: CGS, 4-multiframe ILAS, then user data.
// Optional `JESD_TX_CHAR_REPLACE_EN enables /F/ and /A/ character replacement in DATA.
module jesd204b_tx_link_ctrl
    import jesd204b_pkg::*;
#(
    parameter int F       = 2,
    parameter int K       = 32,
    parameter int ILAS_MF = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_sync_n,
    input  logic [111:0] i_cfg,
    input  logic [7:0]   i_tx_data,
    output logic         o_tx_ready,
    output logic [7:0]   o_enc_data,
    output logic         o_enc_k,
    output logic         o_enc_vld,
    output logic [1:0]   o_state,
    output logic         o_lmfc
);

    localparam int CNT_W = $clog2(F * K);

    link_state_t      state, state_nx;
    logic             sync_seen, sync_seen_nx;
    logic [1:0]       lo_cnt, lo_cnt_nx;
    logic [1:0]       mf_idx, mf_idx_nx;
    logic             resync;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt;
    logic             lmfc, mf_end, frm_end;

    logic [7:0]  data_p0;
    logic        k_p0, vld_p0;
    logic [7:0]  data_p1;
    logic        k_p1, vld_p1, ready_p1, lmfc_p1;
    link_state_t state_p1;

    function automatic logic [8:0] ilas_octet(input logic [15:0] j, input logic [1:0] m,
                                              input logic last, input logic [111:0] cfg);
        logic [3:0] idx;
        idx = j[3:0] - 4'd2;
        if (j == 16'd0)
            return {1'b1, K28_0};
        else if (last)
            return {1'b1, K28_3};
        else if (m == 2'd1 && j == 16'd1)
            return {1'b1, K28_4};
        else if (m == 2'd1 && j >= 16'd2 && j < 16'(2 + ILAS_CFG_OCTETS))
            return {1'b0, cfg[{idx, 3'b000} +: 8]};
        else
            return {1'b0, j[7:0]};
    endfunction

    assign cnt_clr = (state == ST_IDLE) || !i_en;

    jesd204b_lmfc_cnt #(.F(F), .K(K), .CNT_W(CNT_W)) u_lmfc (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .cnt     (cnt),
        .lmfc    (lmfc),
        .mf_end  (mf_end),
        .frm_end (frm_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            sync_seen <= 1'b0;
            lo_cnt    <= '0;
            mf_idx    <= '0;
        end else begin
            state     <= state_nx;
            sync_seen <= sync_seen_nx;
            lo_cnt    <= lo_cnt_nx;
            mf_idx    <= mf_idx_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        sync_seen_nx = sync_seen;
        lo_cnt_nx    = lo_cnt;
        mf_idx_nx    = mf_idx;
        resync       = 1'b0;
        // Loss-of-sync watch runs once the receiver has released SYNC~ at least once.
        if (state == ST_ILAS || state == ST_DATA || (state == ST_CGS && sync_seen)) begin
            if (i_sync_n)
                lo_cnt_nx = '0;
            else if (lo_cnt == 2'(SYNC_RESYNC_CNT - 1))
                resync = 1'b1;
            else
                lo_cnt_nx = lo_cnt + 2'd1;
        end
        case (state)
            ST_IDLE: if (i_en) state_nx = ST_CGS;
            ST_CGS: begin
                if (i_sync_n) sync_seen_nx = 1'b1;
                if ((sync_seen || i_sync_n) && mf_end) begin
                    state_nx  = ST_ILAS;
                    mf_idx_nx = '0;
                end
            end
            ST_ILAS: begin
                if (mf_end) begin
                    mf_idx_nx = mf_idx + 2'd1;
                    if (mf_idx == 2'(ILAS_MF - 1)) state_nx = ST_DATA;
                end
            end
            default: ;
        endcase
        if (resync || !i_en) begin
            state_nx     = i_en ? ST_CGS : ST_IDLE;
            sync_seen_nx = 1'b0;
            lo_cnt_nx    = '0;
            mf_idx_nx    = '0;
        end
    end

`ifdef JESD_TX_CHAR_REPLACE_EN
    logic       ref_vld;
    logic [7:0] ref_octet;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ref_vld <= 1'b0;
        else if (state != ST_DATA)
            ref_vld <= 1'b0;
        else if (frm_end)
            ref_vld <= 1'b1;
    end

    // Reference keeps the original user octet, never the substituted character.
    always_ff @(posedge clk) begin
        if (state == ST_DATA && frm_end)
            ref_octet <= i_tx_data;
    end
`else
    logic unused_frm_end;
    assign unused_frm_end = frm_end;
`endif

    // Stage p0: octet selection from current state and counters
    always_comb begin
        data_p0 = 8'h00;
        k_p0    = 1'b0;
        vld_p0  = 1'b0;
        case (state)
            ST_CGS: begin
                data_p0 = K28_5;
                k_p0    = 1'b1;
                vld_p0  = 1'b1;
            end
            ST_ILAS: begin
                {k_p0, data_p0} = ilas_octet(16'(cnt), mf_idx, mf_end, i_cfg);
                vld_p0          = 1'b1;
            end
            ST_DATA: begin
                data_p0 = i_tx_data;
                vld_p0  = 1'b1;
`ifdef JESD_TX_CHAR_REPLACE_EN
                if (frm_end && ref_vld && i_tx_data == ref_octet) begin
                    k_p0    = 1'b1;
                    data_p0 = mf_end ? K28_3 : K28_7;
                end
`endif
            end
            default: ;
        endcase
    end

    // Stage p1: registered encoder interface
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p1  <= 8'h00;
            k_p1     <= 1'b0;
            vld_p1   <= 1'b0;
            ready_p1 <= 1'b0;
            lmfc_p1  <= 1'b0;
            state_p1 <= ST_IDLE;
        end else begin
            data_p1  <= data_p0;
            k_p1     <= k_p0;
            vld_p1   <= vld_p0;
            ready_p1 <= (state_nx == ST_DATA);
            lmfc_p1  <= lmfc;
            state_p1 <= state;
        end
    end

    assign o_enc_data = data_p1;
    assign o_enc_k    = k_p1;
    assign o_enc_vld  = vld_p1;
    assign o_tx_ready = ready_p1;
    assign o_lmfc     = lmfc_p1;
    assign o_state    = state_p1;

endmodule

// File: tb/tb_jesd204b_tx_link_ctrl.sv
// Directed scoreboard bench for jesd204b_tx_link_ctrl (F=2, K=32).
`timescale 1ns/1ps
module tb_jesd204b_tx_link_ctrl;

    localparam int F  = 2;
    localparam int K  = 32;
    localparam int FK = F * K;
    localparam logic [9:0] EXP_K285 = 10'h3BC;

    logic         clk;
    logic         rst;
    logic         i_en;
    logic         i_sync_n;
    logic [111:0] i_cfg;
    logic [7:0]   i_tx_data;
    logic         o_tx_ready;
    logic [7:0]   o_enc_data;
    logic         o_enc_k;
    logic         o_enc_vld;
    logic [1:0]   o_state;
    logic         o_lmfc;

    int         n_asrt;
    int         n_fail;
    int         d_idx;
    logic [7:0] prev_last;
    logic [7:0] cfg_tab [14];
    logic [9:0] sb [$];

    jesd204b_tx_link_ctrl #(.F(F), .K(K), .ILAS_MF(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_sync_n   (i_sync_n),
        .i_cfg      (i_cfg),
        .i_tx_data  (i_tx_data),
        .o_tx_ready (o_tx_ready),
        .o_enc_data (o_enc_data),
        .o_enc_k    (o_enc_k),
        .o_enc_vld  (o_enc_vld),
        .o_state    (o_state),
        .o_lmfc     (o_lmfc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [9:0] e;
        n_asrt++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty queue expected an entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(tag, 32'({o_enc_vld, o_enc_k, o_enc_data}), 32'(e));
        end
    endtask

    function automatic logic [9:0] ilas_exp(input int m, input int j);
        if (j == 0)               return 10'h31C;
        if (j == FK - 1)          return 10'h37C;
        if (m == 1 && j == 1)     return 10'h39C;
        if (m == 1 && j >= 2 && j <= 15) return {2'b10, cfg_tab[j - 2]};
        return {2'b10, 8'(j)};
    endfunction

    task automatic push_data(input logic [7:0] v);
        logic [9:0] e;
        e = {2'b10, v};
`ifdef JESD_TX_CHAR_REPLACE_EN
        if ((d_idx % F) == F - 1) begin
            if (d_idx >= F && v == prev_last)
                e = {2'b11, ((d_idx % FK) == FK - 1) ? 8'h7C : 8'hFC};
            prev_last = v;
        end
`endif
        sb.push_back(e);
        i_tx_data = v;
        d_idx++;
    endtask

    initial begin
        int w;
        n_asrt    = 0;
        n_fail    = 0;
        d_idx     = 0;
        prev_last = 8'h00;
        rst       = 1'b1;
        i_en      = 1'b0;
        i_sync_n  = 1'b0;
        i_tx_data = 8'h00;
        i_cfg     = '0;
        for (int n = 0; n < 14; n++) begin
            cfg_tab[n]        = 8'hA0 + 8'(n * 3);
            i_cfg[8 * n +: 8] = cfg_tab[n];
        end
        tick();
        tick();
        chk("rst_data",  32'(o_enc_data), 32'h00);
        chk("rst_k",     32'(o_enc_k),    32'h0);
        chk("rst_vld",   32'(o_enc_vld),  32'h0);
        chk("rst_ready", 32'(o_tx_ready), 32'h0);
        chk("rst_state", 32'(o_state),    32'h0);
        chk("rst_lmfc",  32'(o_lmfc),     32'h0);

        // Enable with SYNC~ held low: CGS from the second clock
        rst  = 1'b0;
        i_en = 1'b1;
        tick();
        chk("idle_vld",   32'(o_enc_vld), 32'h0);
        chk("idle_state", 32'(o_state),   32'h0);
        sb.push_back(EXP_K285);
        tick();
        pop_chk("cgs_first");
        chk("cgs_state", 32'(o_state), 32'h1);
        chk("cgs_lmfc0", 32'(o_lmfc),  32'h1);
        repeat (9) begin
            sb.push_back(EXP_K285);
            tick();
            pop_chk("cgs");
            chk("cgs_state", 32'(o_state), 32'h1);
        end

        // Release SYNC~ at LMFC count 10; CGS continues to the boundary
        i_sync_n = 1'b1;
        for (int c = 0; c < FK - 10; c++) begin
            sb.push_back(EXP_K285);
            tick();
            pop_chk("cgs_wait");
            chk("cgs_wait_lmfc", 32'(o_lmfc), 32'h0);
        end

        for (int m = 0; m < 4; m++)
            for (int j = 0; j < FK; j++)
                sb.push_back(ilas_exp(m, j));
        for (int n = 0; n < 4 * FK; n++) begin
            tick();
            pop_chk($sformatf("ilas%0d", n));
            chk("ilas_state", 32'(o_state), 32'h2);
            chk("ilas_lmfc",  32'(o_lmfc),  32'((n % FK) == 0));
        end
        chk("data_ready_first", 32'(o_tx_ready), 32'h1);

        for (int n = 0; n < 20; n++) begin
            push_data(8'h40 + 8'(n));
            tick();
            pop_chk($sformatf("data%0d", n));
            chk("data_state", 32'(o_state),    32'h3);
            chk("data_ready", 32'(o_tx_ready), 32'h1);
        end

`ifdef JESD_TX_CHAR_REPLACE_EN
        push_data(8'h11); tick(); pop_chk("repl_a");
        push_data(8'h22); tick(); pop_chk("repl_b");
        push_data(8'h33); tick(); pop_chk("repl_c");
        push_data(8'h22); tick(); pop_chk("repl_d");
        chk("repl_fc", 32'({o_enc_k, o_enc_data}), 32'h1FC);
        while (d_idx < FK) begin
            push_data(((d_idx % 2) == 1) ? 8'h55 : 8'(d_idx));
            tick();
            pop_chk($sformatf("repl%0d", d_idx));
        end
        chk("repl_a_char", 32'({o_enc_k, o_enc_data}), 32'h17C);
`endif

        // SYNC~ low for 3 cycles only: link stays in DATA
        for (int n = 0; n < 8; n++) begin
            i_sync_n = (n >= 3);
            push_data(8'h80 + 8'(n));
            tick();
            pop_chk($sformatf("sync3_%0d", n));
            chk("sync3_state", 32'(o_state), 32'h3);
        end

        // SYNC~ low for 4 cycles: resync back to CGS
        i_sync_n = 1'b0;
        for (int n = 0; n < 4; n++) begin
            push_data(8'hC0 + 8'(n));
            tick();
            pop_chk($sformatf("sync4_%0d", n));
            chk("sync4_state", 32'(o_state), 32'h3);
        end
        chk("resync_ready", 32'(o_tx_ready), 32'h0);
        sb.push_back(EXP_K285);
        tick();
        pop_chk("resync_k285");
        chk("resync_state", 32'(o_state), 32'h1);

        // Reach ILAS again, then assert reset mid-sequence
        i_sync_n = 1'b1;
        w = 0;
        while (o_state != 2'd2 && w < 200) begin
            tick();
            w++;
        end
        chk("reilas_reach", 32'(o_state), 32'h2);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("arst_data",  32'(o_enc_data), 32'h00);
        chk("arst_k",     32'(o_enc_k),    32'h0);
        chk("arst_vld",   32'(o_enc_vld),  32'h0);
        chk("arst_ready", 32'(o_tx_ready), 32'h0);
        chk("arst_state", 32'(o_state),    32'h0);
        chk("arst_lmfc",  32'(o_lmfc),     32'h0);
        tick();
        rst      = 1'b0;
        i_en     = 1'b1;
        i_sync_n = 1'b0;
        tick();
        chk("rst_idle_vld", 32'(o_enc_vld), 32'h0);
        sb.push_back(EXP_K285);
        tick();
        pop_chk("rst_cgs");
        chk("rst_cgs_lmfc",  32'(o_lmfc),  32'h1);
        chk("rst_cgs_state", 32'(o_state), 32'h1);

        // Disable: vld holds one more clock, then IDLE
        i_en = 1'b0;
        tick();
        chk("dis_vld_hold", 32'(o_enc_vld), 32'h1);
        tick();
        chk("dis_vld",   32'(o_enc_vld), 32'h0);
        chk("dis_state", 32'(o_state),   32'h0);
        chk("dis_lmfc",  32'(o_lmfc),    32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/jesd204b_tx_link_ctrl.md
Name: jesd204b_tx_link_ctrl

Overview:
- Single-lane JESD204B transmit link-layer sequencer; drives the 8b/10b encoder's octet, K-flag and valid inputs, one octet per clk.
- Runs Code Group Synchronisation (CGS), the 4-multiframe Initial Lane Alignment Sequence (ILAS), then user data, under control of the receiver's SYNC~ signal.
- Sits between the transport layer (user octets) and the encoder.

Parameters:
- F, 2, octets per frame (1..16)
- K, 32, frames per multiframe; F*K must be 17..1024
- ILAS_MF, 4, multiframes in ILAS (fixed at 4 in v1; other values unsupported)

Ports:
- clk  input  1  octet clock
- rst  input  1  reset, asynchronous, active-high
- i_en  input  1  link enable; 0 forces IDLE
- i_sync_n  input  1  SYNC~ from receiver, active low, already synchronised to clk
- i_cfg  input  112  ILAS config octets 0..13; octet n = i_cfg[8n+7:8n]
- i_tx_data  input  8  user octet
- o_tx_ready  output  1  user octet consumed this cycle
- o_enc_data  output  8  octet to encoder (HGFEDCBA)
- o_enc_k  output  1  1 = control character
- o_enc_vld  output  1  octet valid to encoder
- o_state  output  2  0 IDLE, 1 CGS, 2 ILAS, 3 DATA
- o_lmfc  output  1  one-cycle pulse on the first octet of each multiframe

Behaviour:
- All outputs registered; reset values: o_enc_data=0x00, o_enc_k=0, o_enc_vld=0, o_tx_ready=0, o_state=0, o_lmfc=0. Octet counter and LMFC counter reset to 0.
- LMFC counter: 0..F*K-1, free-running while i_en=1, wraps to 0.
- o_lmfc=1 when the counter equals 0. The counter is held at 0 in IDLE.
- Output latency: 1 clk from the state/counter values to o_enc_*.
- o_tx_ready is asserted in the same cycle that i_tx_data is sampled. The octet appears on o_enc_data on the next clk.
- State machine:
  - IDLE: o_enc_vld=0. Go to CGS when i_en=1.
  - CGS: emit K28.5 (0xBC, k=1) every cycle. When i_sync_n=1 is sampled, move to ILAS at the next LMFC boundary (counter wraps to 0). If i_sync_n is 1 on the wrap cycle itself, ILAS starts at that boundary.
  - ILAS: ILAS_MF multiframes; m = multiframe index 0..3, j = octet index in the multiframe.
    - j=0: /R/ K28.0 (0x1C, k=1).
    - j=F*K-1: /A/ K28.3 (0x7C, k=1).
    - m=1, j=1: /Q/ K28.4 (0x9C, k=1).
    - m=1, j=2..15: i_cfg octet j-2, k=0.
    - All other octets: ramp, data = j[7:0], k=0.
    - After the last /A/ of m=3, go to DATA.
  - DATA: o_tx_ready=1 every cycle; o_enc_data=i_tx_data, k=0.
- Resync: in CGS-exit wait, ILAS or DATA, if i_sync_n=0 is sampled on 4 consecutive cycles, go to CGS on the next cycle.
  - The first K28.5 is output 1 clk later.
  - The consecutive-low counter clears on any i_sync_n=1.
- i_en=0 in any state: IDLE next cycle. o_enc_vld drops 1 clk later; counters clear.
- rst asserted mid-operation: all outputs immediately return to their reset values (asynchronous).
- i_cfg is sampled live during ILAS multiframe 1. It must be held stable from CGS exit until DATA.
- Frame boundary: octet counter mod F; tracked in DATA only for the optional feature.

Optional Feature:
- Macro: JESD_TX_CHAR_REPLACE_EN.
- With the macro, in DATA (non-scrambled link) the last octet of each frame is compared with the last octet of the previous frame:
  - If equal and at the end of a multiframe, send /A/ 0x7C with k=1.
  - If equal and not at the end of a multiframe, send /F/ K28.7 (0xFC) with k=1.
  - Otherwise send the octet unchanged.
  - The first frame after entering DATA is never replaced. The comparison reference always holds the original user octet.
- Without the macro, DATA octets always pass through with k=0.

Decomposition:
- Package jesd204b_pkg holds:
  - K-character constants: K28_0=0x1C, K28_3=0x7C, K28_4=0x9C, K28_5=0xBC, K28_7=0xFC.
  - State enum and encodings.
  - Constants ILAS_CFG_OCTETS=14 and SYNC_RESYNC_CNT=4.
- One sub-module, jesd204b_lmfc_cnt: multiframe/frame octet counter with wrap and o_lmfc pulse generation, parameterised by F and K.

Test Plan:
- Reset, then i_en=1 with i_sync_n=0 → from the 2nd clk, o_state=1 and o_enc_data=0xBC, k=1, vld=1 continuously.
- F=2, K=32: raise i_sync_n at LMFC count 10 → ILAS starts at count 0; j=0 is 0x1C, j=63 is 0x7C, m=1 j=1 is 0x9C, and m=1 j=2..15 equal i_cfg; 256 ILAS octets, then o_state=3.
- DATA with an incrementing i_tx_data → o_enc_data equals i_tx_data delayed 1 clk, k=0, o_tx_ready=1.
- In DATA, i_sync_n low for 3 cycles then high → stays in DATA; low for 4 cycles → CGS and 0xBC output.
- With JESD_TX_CHAR_REPLACE_EN, F=2: frames (0x11,0x22),(0x33,0x22) → second 0x22 is sent as 0xFC, k=1; repeated last octet at multiframe end → 0x7C.
- Assert rst mid-ILAS → outputs 0 immediately; release with i_en=1 → CGS restarts with the LMFC count at 0.
